// File: rtl/updown_counter_mod.sv
// Loadable up/down counter with programmable modulus, wrap or saturate at the bounds,
// sticky overflow flag, registered compare-match pulse and terminal-count flags.
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 2**WIDTH-1,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             match,
  output logic             ovf,
  output logic             tc_up,
  output logic             tc_dn
);

  localparam logic [WIDTH:0]   MAX_EXT = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic             ovf_evt;
  logic [WIDTH:0]   up_ext, dn_ext;

  assign up_ext = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
  assign dn_ext = {1'b0, count_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    ovf_evt = 1'b0;
    if (ld) begin
      count_d = (data_in > MAX_W) ? MAX_W : data_in;
    end else if (inc && !dec) begin
      if (up_ext > MAX_EXT) begin
        ovf_evt = 1'b1;
        count_d = (SATURATE != 0) ? count_q : '0;
      end else begin
        count_d = up_ext[WIDTH-1:0];
      end
    end else if (dec && !inc) begin
      // Borrow out of the extended subtraction means q was already zero.
      if (dn_ext[WIDTH]) begin
        ovf_evt = 1'b1;
        count_d = (SATURATE != 0) ? count_q : MAX_W;
      end else begin
        count_d = dn_ext[WIDTH-1:0];
      end
    end
  end

  assign match_d = (count_d == cmp_val) && (count_d != count_q);
  assign ovf_d   = ovf_evt | (ovf_q & ~ovf_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q     = count_q;
  assign match = match_q;
  assign ovf   = ovf_q;
  assign tc_up = (count_q == MAX_W);
  assign tc_dn = (count_q == '0);

endmodule
